// File: rtl/leaf_packetizer.sv
// leaf_packetizer: round-robin packetizer that wraps user stream words into BFT packets,
// with a per-stream destination table, sequence numbering and credit flow control.
module leaf_packetizer #(
  parameter int PACKET_BITS   = 49,
  parameter int PAYLOAD_BITS  = 32,
  parameter int NUM_LEAF_BITS = 5,
  parameter int NUM_PORT_BITS = 4,
  parameter int NUM_SEQ_BITS  = 7,
  parameter int NUM_OUT_PORTS = 2,
  parameter int CREDIT_INIT   = 64
) (
  input  logic                                    clk_bft,
  input  logic                                    reset_n,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]   din_leaf_user2interface,
  input  logic [NUM_OUT_PORTS-1:0]                vld_user2interface,
  output logic [NUM_OUT_PORTS-1:0]                ack_interface2user,
  input  logic                                    cfg_we,
  input  logic [3:0]                              cfg_stream,
  input  logic [NUM_LEAF_BITS-1:0]                cfg_leaf,
  input  logic [NUM_PORT_BITS-1:0]                cfg_port,
  input  logic                                    credit_we,
  input  logic [3:0]                              credit_stream,
  input  logic [7:0]                              credit_amt,
  output logic [PACKET_BITS-1:0]                  dout_leaf_interface2bft,
  input  logic                                    out_ready
);
  localparam int CW = $clog2(CREDIT_INIT + 1);
  localparam int RW = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;
  localparam int XW = CW + 9;

  if (PACKET_BITS != 1 + NUM_LEAF_BITS + NUM_PORT_BITS + NUM_SEQ_BITS + PAYLOAD_BITS) begin : g_width_check
    $error("PACKET_BITS must equal 1+NUM_LEAF_BITS+NUM_PORT_BITS+NUM_SEQ_BITS+PAYLOAD_BITS");
  end

  logic [NUM_OUT_PORTS-1:0] cfg_valid_q, cfg_valid_d, elig;
  logic [NUM_LEAF_BITS-1:0] leaf_q [NUM_OUT_PORTS];
  logic [NUM_LEAF_BITS-1:0] leaf_d [NUM_OUT_PORTS];
  logic [NUM_PORT_BITS-1:0] port_q [NUM_OUT_PORTS];
  logic [NUM_PORT_BITS-1:0] port_d [NUM_OUT_PORTS];
  logic [NUM_SEQ_BITS-1:0]  seq_q [NUM_OUT_PORTS];
  logic [NUM_SEQ_BITS-1:0]  seq_d [NUM_OUT_PORTS];
  logic [CW-1:0]            credit_q [NUM_OUT_PORTS];
  logic [CW-1:0]            credit_d [NUM_OUT_PORTS];
  logic [RW-1:0]            rr_q, rr_d;
  logic [PACKET_BITS-1:0]   dout_q, dout_d;
  logic                     free, gnt_any, hi_any, lo_any, hit;
  int                       g, hi, lo;
  logic [XW-1:0]            c;

  // Round robin: lowest eligible stream at or above rr_q, else lowest eligible overall.
  always_comb begin
    free = !dout_q[PACKET_BITS-1] || out_ready;
    hi_any = 1'b0;
    lo_any = 1'b0;
    hi = 0;
    lo = 0;
    for (int p = NUM_OUT_PORTS - 1; p >= 0; p--) begin
      elig[p] = vld_user2interface[p] && cfg_valid_q[p] && (credit_q[p] != '0);
      if (elig[p]) begin
        lo_any = 1'b1;
        lo = p;
      end
      if (elig[p] && p >= int'(rr_q)) begin
        hi_any = 1'b1;
        hi = p;
      end
    end
    gnt_any = free && (hi_any || lo_any);
    g = hi_any ? hi : lo;
    for (int p = 0; p < NUM_OUT_PORTS; p++) ack_interface2user[p] = reset_n && gnt_any && (g == p);
  end

  always_comb begin
    cfg_valid_d = cfg_valid_q;
    leaf_d = leaf_q;
    port_d = port_q;
    seq_d = seq_q;
    credit_d = credit_q;
    rr_d = rr_q;
    dout_d = dout_q;
    hit = 1'b0;
    c = '0;
    if (!gnt_any && out_ready) dout_d[PACKET_BITS-1] = 1'b0;
    for (int p = 0; p < NUM_OUT_PORTS; p++) begin
      hit = gnt_any && (g == p);
      if (hit) begin
        dout_d = {1'b1, leaf_q[p], port_q[p], seq_q[p], din_leaf_user2interface[p*PAYLOAD_BITS +: PAYLOAD_BITS]};
        seq_d[p] = seq_q[p] + 1'b1;
        rr_d = RW'((p + 1) % NUM_OUT_PORTS);
      end
      c = XW'(credit_q[p]) - XW'(hit);
      if (credit_we && credit_stream == 4'(p))
        c = (c + XW'(credit_amt) > XW'(CREDIT_INIT)) ? XW'(CREDIT_INIT) : c + XW'(credit_amt);
      credit_d[p] = CW'(c);
      if (cfg_we && cfg_stream == 4'(p)) begin
        cfg_valid_d[p] = 1'b1;
        leaf_d[p] = cfg_leaf;
        port_d[p] = cfg_port;
      end
    end
  end

  always_ff @(posedge clk_bft or negedge reset_n) begin
    if (!reset_n) begin
      cfg_valid_q <= '0;
      rr_q <= '0;
      dout_q <= '0;
      for (int p = 0; p < NUM_OUT_PORTS; p++) begin
        leaf_q[p] <= '0;
        port_q[p] <= '0;
        seq_q[p] <= '0;
        credit_q[p] <= CW'(CREDIT_INIT);
      end
    end else begin
      cfg_valid_q <= cfg_valid_d;
      leaf_q <= leaf_d;
      port_q <= port_d;
      seq_q <= seq_d;
      credit_q <= credit_d;
      rr_q <= rr_d;
      dout_q <= dout_d;
    end
  end

  assign dout_leaf_interface2bft = dout_q;
endmodule

// File: doc/leaf_packetizer.md
LEAF_PACKETIZER -- requirements
Module: leaf_packetizer

Interface
REQ-001 The block SHALL expose these parameters, one per line: name, default, meaning.
- PACKET_BITS, 49, BFT packet width.
- PAYLOAD_BITS, 32, user word width.
- NUM_LEAF_BITS, 5, destination leaf field width.
- NUM_PORT_BITS, 4, destination port field width.
- NUM_SEQ_BITS, 7, sequence field width.
- NUM_OUT_PORTS, 2, user output streams, 1..16.
- CREDIT_INIT, 64, per-stream credit ceiling.
REQ-002 PACKET_BITS SHALL equal 1+NUM_LEAF_BITS+NUM_PORT_BITS+NUM_SEQ_BITS+PAYLOAD_BITS; elaboration SHALL fail otherwise.
REQ-003 The ports SHALL be, one per line: name, direction, width, meaning.
- clk_bft, in, 1, sole clock; all state on the rising edge.
- reset_n, in, 1, asynchronous active-low reset.
- din_leaf_user2interface, in, NUM_OUT_PORTS*PAYLOAD_BITS, user words, stream p at [p*PAYLOAD_BITS +: PAYLOAD_BITS].
- vld_user2interface, in, NUM_OUT_PORTS, per-stream word valid.
- ack_interface2user, out, NUM_OUT_PORTS, per-stream accept strobe.
- cfg_we, in, 1, destination-table write strobe.
- cfg_stream, in, 4, stream index written.
- cfg_leaf, in, NUM_LEAF_BITS, destination leaf.
- cfg_port, in, NUM_PORT_BITS, destination port.
- credit_we, in, 1, credit-return strobe.
- credit_stream, in, 4, stream index credited.
- credit_amt, in, 8, words returned.
- dout_leaf_interface2bft, out, PACKET_BITS, packet; bit MSB is packet-valid.
- out_ready, in, 1, downstream accepts packet this cycle.

Function
REQ-004 Packet layout, MSB to LSB: valid, dst leaf, dst port, sequence, payload.
REQ-005 Per stream, the block SHALL hold: cfg_valid, dst leaf, dst port, credit counter (width clog2(CREDIT_INIT+1)), NUM_SEQ_BITS sequence counter.
REQ-006 A stream is eligible when vld=1, cfg_valid=1 and credit>0.
REQ-007 Output register is free when packet-valid=0 or out_ready=1 in the same cycle.
REQ-008 When free and at least one stream is eligible, the block SHALL grant exactly one stream by round robin, searching from rr_ptr upward with wrap from NUM_OUT_PORTS-1 to 0.
REQ-009 ack_interface2user[g] SHALL be combinationally high in the grant cycle only; all other ack bits SHALL be 0.
REQ-010 On the following edge the output register SHALL load {1, dst leaf[g], dst port[g], seq[g], word g}; latency from grant to packet = 1 cycle.
REQ-011 On a grant, seq[g] SHALL increment modulo 2^NUM_SEQ_BITS, wrapping 127->0 at the default width, credit[g] SHALL decrement, and rr_ptr SHALL become g+1 mod NUM_OUT_PORTS.
REQ-012 Without a grant, rr_ptr SHALL be unchanged; packet-valid SHALL clear when out_ready=1.
REQ-013 While packet-valid=1 and out_ready=0, dout SHALL hold stable and no grant SHALL occur.
REQ-014 On credit_we, credit[credit_stream] SHALL become min(CREDIT_INIT, credit - grant + credit_amt), with grant=1 if the same stream is granted that cycle.
REQ-015 credit_stream >= NUM_OUT_PORTS SHALL be ignored.
REQ-016 On cfg_we, the table entry SHALL be written and cfg_valid set, effective from the next cycle's arbitration.
REQ-017 A packet already in the output register SHALL keep its old destination.
REQ-018 cfg_stream >= NUM_OUT_PORTS SHALL be ignored.
REQ-019 At credit=0 the stream SHALL stall with ack=0 and its word unconsumed.

Reset
REQ-020 reset_n=0 SHALL asynchronously clear dout to 0, all cfg_valid, all seq counters and rr_ptr to 0, and load all credits to CREDIT_INIT.
REQ-021 ack_interface2user SHALL be 0 while reset_n=0.
REQ-022 Release SHALL be synchronous; the first grant is possible on the first edge after deassertion.
REQ-023 Reset mid-transfer SHALL discard the output-register packet.

Verification
REQ-024 Configure stream 0 -> leaf 3, port 1; drive word 0xDEADBEEF with vld, out_ready=1 -> ack0 pulses for one cycle; next cycle dout = {1, 5'd3, 4'd1, 7'd0, 32'hDEADBEEF}.
REQ-025 Both streams configured, vld continuously high, out_ready=1 -> grants alternate 0,1,0,1; each stream's sequence field counts 0,1,2,...
REQ-026 Stream 0 sends 64 words with no credit return -> 65th word gets no ack; credit_we stream 0 amt 4 -> exactly 4 further packets issue.
REQ-027 out_ready=0 for 5 cycles with a packet pending -> dout unchanged, all ack=0; out_ready=1 -> next packet issues the following cycle.
REQ-028 Send 130 words on stream 1, returning credits -> sequence field wraps 127->0 at the 129th packet.
REQ-029 Assert reset_n=0 mid-stream -> dout=0 and ack=0 immediately; after release, an unconfigured stream with vld=1 gets no ack.
